div_ctrl: RTL and testbench

Multi-cycle division sequencer for the HI/LO resource. It accepts a DIV/DIVU request from the execute stage and runs a 32-step shift-subtract division, one quotient bit per clock. It returns {remainder, quotient} for writing to {HI, LO} and holds it until execute releases the request. Execute drives `start_i` and holds its pipeline stall request for as long as `ready_o` is low.

---
 rtl/div_ctrl_pkg.sv | 21 ++
 rtl/div_step.sv | 22 ++
 rtl/div_ctrl.sv | 120 ++++++++++++
 tb/tb_div_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared constants for the HI/LO division sequencer: FSM encodings,
// handshake levels and the ALU op codes that route DIV/DIVU here.
package div_ctrl_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  localparam int unsigned AluOpBusW = 8;
  localparam logic [AluOpBusW-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [AluOpBusW-1:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_step.sv
// One shift-subtract iteration: produces one quotient bit per call.
// work holds {partial remainder, remaining dividend / quotient bits, spare}.
module div_step (
  input  logic [64:0] work_i,
  input  logic [31:0] divisor_i,
  output logic [64:0] work_o
);

  logic [32:0] diff;

  assign diff = work_i[64:32] - {1'b0, divisor_i};

  // diff[32] set means the partial remainder is still below the divisor.
  always_comb begin
    if (diff[32]) begin
      work_o = {work_i[63:0], 1'b0};
    end else begin
      work_o = {diff[31:0], work_i[31:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle DIV/DIVU sequencer: latches magnitudes and signs, runs 32
// steps, then holds {remainder, quotient} until execute drops start_i.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  div_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d, work_step;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] abs_op1, abs_op2, quo_fix, rem_fix;

  assign abs_op1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign abs_op2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign quo_fix = neg_quo_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
  assign rem_fix = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    unique case (state_q)
      DivFree: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_d = DivByZero;
          end else begin
            state_d   = DivOn;
            cnt_d     = 6'd0;
            work_d    = {32'd0, abs_op1, 1'b0};
            divisor_d = abs_op2;
            neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
            neg_rem_d = signed_div_i & opdata1_i[31];
          end
        end
      end
      DivByZero: begin
        work_d   = '0;
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        // A flush wins over both stepping and completion.
        if (annul_i) begin
          state_d = DivFree;
        end else if (cnt_q < 6'd32) begin
          work_d = work_step;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          state_d  = DivEnd;
          result_d = {rem_fix, quo_fix};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          state_d  = DivFree;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end
      default: state_d = DivFree;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DivFree;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= DivResultNotReady;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed and random checks of div_ctrl against an arithmetic reference
// that divides magnitudes with plain / and % and then applies the signs.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  div_ctrl dut (
    .clk          (clk),
    .rst          (rst_n),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] aa, bb, q, r;
    if (b == 32'd0) return 64'h0;
    aa = (s && a[31]) ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
    bb = (s && b[31]) ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    q = aa / bb;
    r = aa % bb;
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after edge 0; follows the operation to END, holds, then releases.
  task automatic finish_div(input string tag, input int lat, input int hold);
    logic [63:0] expv;
    expv = exp_q.pop_front();
    check({tag, "_edge0_ready"}, {63'd0, ready}, 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) begin
        op1 = $urandom;
        op2 = $urandom;
        signed_div = ~signed_div;
      end
      tick();
      if (k == lat - 1) check({tag, "_early_ready"}, {63'd0, ready}, 64'd0);
    end
    check({tag, "_ready"}, {63'd0, ready}, 64'd1);
    check({tag, "_result"}, result, expv);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold"}, {ready, result[62:0]}, {1'b1, expv[62:0]});
    end
    @(negedge clk);
    start = 1'b0;
    tick();
    check({tag, "_release"}, {ready, result[62:0]}, 64'd0);
    check({tag, "_free"}, 64'(dut.state_q), 64'(DivFree));
  endtask

  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] expv);
    exp_q.push_back(expv);
    @(negedge clk);
    signed_div = s;
    op1 = a;
    op2 = b;
    start = 1'b1;
    tick();
  endtask

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expv, input int hold);
    launch(s, a, b, expv);
    finish_div(tag, (b == 32'd0) ? 1 : 33, hold);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    rst_n = 1'b0;
    signed_div = 1'b0;
    op1 = '0;
    op2 = '0;
    start = 1'b0;
    annul = 1'b0;
    #12;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_state", 64'(dut.state_q), 64'(DivFree));
    @(negedge clk);
    rst_n = 1'b1;

    // idle with start low and with annul blocking acceptance
    tick();
    check("idle_ready", {63'd0, ready}, 64'd0);
    @(negedge clk);
    annul = 1'b1;
    start = 1'b1;
    op1 = 32'd10;
    op2 = 32'd2;
    tick();
    check("annul_blocks", 64'(dut.state_q), 64'(DivFree));
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;

    run_div("u100_7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 2);
    run_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
    run_div("s_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 0);
    run_div("u_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0}, 0);
    run_div("div0", 1'b1, 32'd5, 32'd0, 64'h0, 1);

    // annul on edge 10 of 0xFFFFFFFF / 3, then 9 / 3 the next cycle
    launch(1'b0, 32'hFFFF_FFFF, 32'd3, 64'h0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 10) annul = 1'b1;
      tick();
      check("annul_no_ready", {63'd0, ready}, 64'd0);
    end
    check("annul_state", 64'(dut.state_q), 64'(DivFree));
    exp_q.push_back({32'd0, 32'd3});
    @(negedge clk);
    annul = 1'b0;
    op1 = 32'd9;
    op2 = 32'd3;
    tick();
    finish_div("after_annul", 33, 0);

    // asynchronous reset between edges 15 and 16
    launch(1'b0, 32'd1000, 32'd7, 64'h0);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 15; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_out", {ready, result[62:0]}, 64'd0);
    check("rst_mid_state", 64'(dut.state_q), 64'(DivFree));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_div("u20_4", 1'b0, 32'd20, 32'd4, {32'd0, 32'd5}, 0);

    // asynchronous reset while a result is held
    launch(1'b1, 32'd12345, 32'hFFFF_FFF0, model(1'b1, 32'd12345, 32'hFFFF_FFF0));
    for (int k = 1; k <= 33; k++) tick();
    check("end_before_rst", result, exp_q.pop_front());
    #2 rst_n = 1'b0;
    #1;
    check("rst_end_out", {ready, result[62:0]}, 64'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // operands scrambled during ON, start held through END
    run_div("latched_ops", 1'b0, 32'd1234567, 32'd89, {32'd48, 32'd13871}, 4);

    // random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 15);
        3:       rb = 32'hFFFF_FFFF - $urandom_range(0, 3);
        default: rb = $urandom;
      endcase
      run_div("rand", rs, ra, rb, model(rs, ra, rb), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
